pipe_hazard_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 22 ++
 rtl/hazard_scoreboard.sv | 66 ++++++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 4-stage core: register width, R0, FSM and branch-select encodings.
package core_pkg;

    localparam int unsigned REG_AW = 5;

    // R0 reads as zero and ignores writes, so it never carries a dependency.
    localparam logic [REG_AW-1:0] R0 = '0;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BsNone = 2'b00,
        BsCond = 2'b01,
        BsJreg = 2'b10,
        BsJump = 2'b11
    } bs_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight write tracker (EX and WB slots) plus the combinational RAW check for the DOF stage.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = core_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_adv,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_da,
    input  logic [REG_AW-1:0] i_aa,
    input  logic [REG_AW-1:0] i_ba,
    input  logic              i_rw,
    input  logic              i_ma,
    input  logic              i_mb,
    output logic              o_hazard,
    output logic              o_ex_valid,
    output logic              o_ex_rw,
    output logic [REG_AW-1:0] o_ex_da,
    output logic              o_wb_valid,
    output logic              o_wb_rw,
    output logic [REG_AW-1:0] o_wb_da
);

    logic              r_ex_valid, r_ex_rw, r_wb_valid, r_wb_rw;
    logic [REG_AW-1:0] r_ex_da, r_wb_da;
    logic              w_ex_hit, w_wb_hit;

    // Slot shift: WB takes EX, EX takes the DOF instruction only when it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_rw    <= 1'b0;
            r_ex_da    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rw    <= 1'b0;
            r_wb_da    <= '0;
        end else if (!i_hold) begin
            r_wb_valid <= r_ex_valid;
            r_wb_rw    <= r_ex_rw;
            r_wb_da    <= r_ex_da;
            r_ex_valid <= i_adv && i_valid;
            r_ex_rw    <= i_adv && i_rw;
            r_ex_da    <= i_adv ? i_da : '0;
        end
    end

    // A slot blocks DOF only if it will really write a nonzero register that DOF reads.
    always_comb begin
        w_ex_hit = r_ex_valid && r_ex_rw && (r_ex_da != R0) &&
                   (((r_ex_da == i_aa) && !i_ma) || ((r_ex_da == i_ba) && !i_mb));
        w_wb_hit = r_wb_valid && r_wb_rw && (r_wb_da != R0) &&
                   (((r_wb_da == i_aa) && !i_ma) || ((r_wb_da == i_ba) && !i_mb));
        o_hazard = i_valid && (w_ex_hit || w_wb_hit);
    end

    assign o_ex_valid = r_ex_valid;
    assign o_ex_rw    = r_ex_rw;
    assign o_ex_da    = r_ex_da;
    assign o_wb_valid = r_wb_valid;
    assign o_wb_rw    = r_wb_rw;
    assign o_wb_da    = r_wb_da;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall on RAW hazards, flush on taken branches, freeze on hold.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned REG_AW = core_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dof_valid,
    input  logic [REG_AW-1:0] dof_da,
    input  logic [REG_AW-1:0] dof_aa,
    input  logic [REG_AW-1:0] dof_ba,
    input  logic              dof_rw,
    input  logic              dof_ma,
    input  logic              dof_mb,
    input  logic [1:0]        dof_bs,
    input  logic              ex_br_taken,
    input  logic              hold,
    output logic              pc_en,
    output logic              ifdof_en,
    output logic              ifdof_kill,
    output logic              dofex_kill,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;
    logic              w_hazard, w_adv;
    logic              w_ex_valid, w_ex_rw, w_wb_valid, w_wb_rw;
    logic [REG_AW-1:0] w_ex_da, w_wb_da;
    logic              w_unused;

    // Branch select is decoded in EX; slot contents are exported for debug only.
    assign w_unused = ^{dof_bs, w_ex_valid, w_ex_rw, w_ex_da, w_wb_valid, w_wb_rw, w_wb_da};

    hazard_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (hold),
        .i_adv      (w_adv),
        .i_valid    (dof_valid),
        .i_da       (dof_da),
        .i_aa       (dof_aa),
        .i_ba       (dof_ba),
        .i_rw       (dof_rw),
        .i_ma       (dof_ma),
        .i_mb       (dof_mb),
        .o_hazard   (w_hazard),
        .o_ex_valid (w_ex_valid),
        .o_ex_rw    (w_ex_rw),
        .o_ex_da    (w_ex_da),
        .o_wb_valid (w_wb_valid),
        .o_wb_rw    (w_wb_rw),
        .o_wb_da    (w_wb_da)
    );

    // Priority decision: reset > hold > taken branch > RAW hazard > run.
    always_comb begin
        pc_en      = 1'b1;
        ifdof_en   = 1'b1;
        ifdof_kill = 1'b0;
        dofex_kill = 1'b0;
        w_state_d  = r_state;
        w_adv      = 1'b0;
        if (rst) begin
            w_state_d = StRun;
        end else if (hold) begin
            pc_en    = 1'b0;
            ifdof_en = 1'b0;
        end else if (ex_br_taken) begin
            // DOF is wrong-path, so any hazard it shows is irrelevant.
            ifdof_kill = 1'b1;
            dofex_kill = 1'b1;
            w_state_d  = StFlush;
        end else if (w_hazard) begin
            pc_en      = 1'b0;
            ifdof_en   = 1'b0;
            dofex_kill = 1'b1;
            w_state_d  = StStall;
        end else begin
            w_state_d = StRun;
            w_adv     = 1'b1;
        end
    end

    // State register and saturating event counters, all frozen under hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StRun;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            r_state <= w_state_d;
            if (ex_br_taken) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (w_hazard) begin
                if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: per-register pending-write model plus directed and random stimulus.
module tb_pipe_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic       v;
        logic [4:0] da;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       rw;
        logic       ma;
        logic       mb;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dof_valid = 1'b0;
    logic [4:0]    dof_da = '0, dof_aa = '0, dof_ba = '0;
    logic          dof_rw = 1'b0, dof_ma = 1'b0, dof_mb = 1'b0;
    logic [1:0]    dof_bs = '0;
    logic          ex_br_taken = 1'b0, hold = 1'b0;
    logic          pc_en, ifdof_en, ifdof_kill, dofex_kill;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(
        .REG_AW (5),
        .CNT_W  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dof_valid   (dof_valid),
        .dof_da      (dof_da),
        .dof_aa      (dof_aa),
        .dof_ba      (dof_ba),
        .dof_rw      (dof_rw),
        .dof_ma      (dof_ma),
        .dof_mb      (dof_mb),
        .dof_bs      (dof_bs),
        .ex_br_taken (ex_br_taken),
        .hold        (hold),
        .pc_en       (pc_en),
        .ifdof_en    (ifdof_en),
        .ifdof_kill  (ifdof_kill),
        .dofex_kill  (dofex_kill),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycles (non-hold) for which a register's pending write still blocks DOF reads.
    int pend [32];
    int m_state, m_stall, m_flush;
    bit keep_dof, bubble_next;
    logic o_pc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit h = 1'b0;
        if (dof_valid) begin
            if (!dof_ma && dof_aa != 0 && pend[dof_aa] > 0) h = 1'b1;
            if (!dof_mb && dof_ba != 0 && pend[dof_ba] > 0) h = 1'b1;
        end
        return h;
    endfunction

    function automatic instr_t mk(input bit v, input int da, input int aa, input int ba,
                                  input bit rw, input bit ma, input bit mb);
        instr_t t;
        t.v = v; t.da = 5'(da); t.aa = 5'(aa); t.ba = 5'(ba);
        t.rw = rw; t.ma = ma; t.mb = mb;
        return t;
    endfunction

    // One clock: drive at negedge, compare everything, then advance the model at posedge.
    task automatic cycle(input instr_t ins, input bit tk, input bit hl, input bit rs);
        bit         h;
        logic [3:0] e;
        @(negedge clk);
        dof_valid = ins.v; dof_da = ins.da; dof_aa = ins.aa; dof_ba = ins.ba;
        dof_rw = ins.rw; dof_ma = ins.ma; dof_mb = ins.mb;
        dof_bs = 2'($urandom_range(0, 3));
        ex_br_taken = tk; hold = hl; rst = rs;
        #1;
        h = model_hazard();
        if (rs)      e = 4'b1100;
        else if (hl) e = 4'b0000;
        else if (tk) e = 4'b1111;
        else if (h)  e = 4'b0001;
        else         e = 4'b1100;
        chk("pc_en",      int'(pc_en),      int'(e[3]));
        chk("ifdof_en",   int'(ifdof_en),   int'(e[2]));
        chk("ifdof_kill", int'(ifdof_kill), int'(e[1]));
        chk("dofex_kill", int'(dofex_kill), int'(e[0]));
        chk("state",      int'(state),      m_state);
        chk("stall_cnt",  int'(stall_cnt),  m_stall);
        chk("flush_cnt",  int'(flush_cnt),  m_flush);
        o_pc = pc_en;
        @(posedge clk);
        if (rs) begin
            foreach (pend[r]) pend[r] = 0;
            m_state = 0; m_stall = 0; m_flush = 0;
        end else if (!hl) begin
            foreach (pend[r]) if (pend[r] > 0) pend[r]--;
            if (tk) begin
                m_state = 2;
                if (m_flush < SAT) m_flush++;
            end else if (h) begin
                m_state = 1;
                if (m_stall < SAT) m_stall++;
            end else begin
                m_state = 0;
                if (ins.v && ins.rw && ins.da != 0) pend[ins.da] = 2;
            end
        end
        keep_dof    = !rs && (hl || (!tk && h));
        bubble_next = !rs && !hl && tk;
        #1;
    endtask

    task automatic do_reset();
        cycle(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
        cycle(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1);
    endtask

    instr_t add3, add4, nop, cur;

    initial begin
        foreach (pend[r]) pend[r] = 0;
        m_state = 0; m_stall = 0; m_flush = 0;
        nop  = mk(0, 0, 0, 0, 0, 0, 0);
        add3 = mk(1, 3, 1, 2, 1, 0, 0);  // ADD R3 <- R1,R2
        add4 = mk(1, 4, 3, 5, 1, 0, 0);  // ADD R4 <- R3,R5

        // Reset state
        do_reset();
        chk("rst_state", int'(state), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk("rst_flush", int'(flush_cnt), 0);

        // Back-to-back dependency: exactly two stall cycles
        cycle(add3, 0, 0, 0);
        cycle(add4, 0, 0, 0);
        chk("b2b_state1", int'(state), 1);
        cycle(add4, 0, 0, 0);
        chk("b2b_state2", int'(state), 1);
        cycle(add4, 0, 0, 0);
        chk("b2b_run", int'(state), 0);
        chk("b2b_cnt", int'(stall_cnt), 2);

        // Immediate B operand is not read
        do_reset();
        cycle(mk(1, 3, 1, 0, 1, 0, 1), 0, 0, 0);
        cycle(mk(1, 6, 7, 3, 1, 0, 1), 0, 0, 0);
        chk("imm_nostall", int'(o_pc), 1);
        chk("imm_cnt", int'(stall_cnt), 0);

        // Writes to R0 never stall
        cycle(mk(1, 0, 1, 2, 1, 0, 0), 0, 0, 0);
        cycle(mk(1, 5, 0, 0, 1, 0, 0), 0, 0, 0);
        chk("r0_nostall", int'(o_pc), 1);
        chk("r0_cnt", int'(stall_cnt), 0);

        // Taken branch overrides a hazard
        do_reset();
        cycle(add3, 0, 0, 0);
        cycle(add4, 1, 0, 0);
        chk("br_state", int'(state), 2);
        chk("br_flush", int'(flush_cnt), 1);
        chk("br_stall", int'(stall_cnt), 0);
        cycle(nop, 0, 0, 0);
        chk("br_after", int'(state), 0);

        // Hold during a stall freezes it; the stall resumes afterwards
        do_reset();
        cycle(add3, 0, 0, 0);
        cycle(add4, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(add4, 0, 1, 0);
        chk("hold_cnt", int'(stall_cnt), 1);
        chk("hold_state", int'(state), 1);
        cycle(add4, 0, 0, 0);
        chk("hold_resume", int'(stall_cnt), 2);
        cycle(add4, 0, 0, 0);
        chk("hold_done", int'(state), 0);

        // Saturation, then reset asserted mid-stall
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(add3, 0, 0, 0);
            for (int j = 0; j < 3; j++) cycle(mk(1, 6, 3, 3, 0, 0, 0), 0, 0, 0);
        end
        chk("sat_full", int'(stall_cnt), SAT);
        cycle(add3, 0, 0, 0);
        cycle(add4, 0, 0, 0);
        chk("sat_hold", int'(stall_cnt), SAT);
        cycle(add4, 0, 0, 1);
        chk("rst_mid_state", int'(state), 0);
        chk("rst_mid_stall", int'(stall_cnt), 0);
        cycle(add4, 0, 0, 0);
        chk("rst_mid_pc", int'(o_pc), 1);

        // Random traffic with a small register pool to make hazards frequent
        do_reset();
        cur = nop;
        for (int i = 0; i < 3000; i++) begin
            if (!keep_dof) begin
                if (bubble_next) cur = nop;
                else cur = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3),
                              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                              $urandom_range(0, 2) == 0);
            end
            cycle(cur, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
